// File: rtl/display_regs_if.sv
// Picoblaze I/O port bus: address, output strobe/data and registered readback data.
interface display_regs_if;
  logic [7:0] port_id;
  logic       write_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;

  modport master (output port_id, write_strobe, out_port, input  in_port);
  modport slave  (input  port_id, write_strobe, out_port, output in_port);
endinterface

// File: rtl/display_regs.sv
// Picoblaze register bank driving a 4-digit seven-segment display (active-low segments).
// Optional digit blinking is built only when DISPLAY_BLINK_EN is defined.

module display_regs_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] nib,
  input  logic       en,
  input  logic       rawm,
  input  logic       dp,
  input  logic       blank,
  input  logic [7:0] raw,
  output logic [7:0] seg
);
  logic [7:0] hex;

  always_comb begin
    hex = 8'hFF;
    case (nib)
      4'h0: hex = 8'hC0;  4'h1: hex = 8'hF9;  4'h2: hex = 8'hA4;  4'h3: hex = 8'hB0;
      4'h4: hex = 8'h99;  4'h5: hex = 8'h92;  4'h6: hex = 8'h82;  4'h7: hex = 8'hF8;
      4'h8: hex = 8'h80;  4'h9: hex = 8'h90;  4'hA: hex = 8'h88;  4'hB: hex = 8'h83;
      4'hC: hex = 8'hC6;  4'hD: hex = 8'hA1;  4'hE: hex = 8'h86;  4'hF: hex = 8'h8E;
      default: hex = 8'hFF;
    endcase
  end

  // Disable beats blink, blink beats raw, raw ignores the decimal point.
  always_ff @(posedge clk) begin
    if (reset)              seg <= 8'hFF;
    else if (!en || blank)  seg <= 8'hFF;
    else if (rawm)          seg <= raw;
    else                    seg <= {hex[7] & ~dp, hex[6:0]};
  end
endmodule

module display_regs #(
  parameter logic [7:0]  BASE_ADDR = 8'h10,
  parameter logic [23:0] BLINK_DIV = 24'd12_500_000
) (
  input  logic                clk,
  input  logic                reset,
  display_regs_if.slave       bus,
  output logic [7:0]          segment0,
  output logic [7:0]          segment1,
  output logic [7:0]          segment2,
  output logic [7:0]          segment3
);
  localparam int NUM_DIG = 4;

`ifdef DISPLAY_BLINK_EN
  localparam logic [7:0] DP_MASK = 8'hFF;
`else
  localparam logic [7:0] DP_MASK = 8'h0F;
`endif

  // rf[0]=DIGIT_LO rf[1]=DIGIT_HI rf[2]=DP rf[3]=CTRL rf[4..7]=RAW0..3
  logic [7:0][7:0]         rf;
  logic [NUM_DIG-1:0][7:0] seg;
  logic [15:0]             digits;
  logic                    hit;
  logic [2:0]              sel;
  logic [7:0]              wmask;
  logic                    blank_ph;

  assign hit    = (bus.port_id[7:3] == BASE_ADDR[7:3]);
  assign sel    = bus.port_id[2:0];
  assign wmask  = (sel == 3'd2) ? DP_MASK : 8'hFF;
  assign digits = {rf[1], rf[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      rf <= {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00};
    end else if (bus.write_strobe && hit) begin
      rf[sel] <= bus.out_port & wmask;
    end
  end

  // Readback samples the pre-write register value, so a same-cycle write reads old data.
  always_ff @(posedge clk) begin
    if (reset)    bus.in_port <= 8'h00;
    else if (hit) bus.in_port <= rf[sel];
    else          bus.in_port <= 8'h00;
  end

`ifdef DISPLAY_BLINK_EN
  logic [23:0] bcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt     <= '0;
      blank_ph <= 1'b0;
    end else if (bcnt == BLINK_DIV - 24'd1) begin
      bcnt     <= '0;
      blank_ph <= ~blank_ph;
    end else begin
      bcnt     <= bcnt + 24'd1;
    end
  end
`else
  logic unused_blink_div;
  assign unused_blink_div = ^BLINK_DIV;
  assign blank_ph = 1'b0;
`endif

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    display_regs_digit u_dig (
      .clk   (clk),
      .reset (reset),
      .nib   (digits[4*g +: 4]),
      .en    (rf[3][g]),
      .rawm  (rf[3][4+g]),
      .dp    (rf[2][g]),
      .blank (blank_ph & rf[2][4+g]),
      .raw   (rf[4+g]),
      .seg   (seg[g])
    );
  end

  assign segment0 = seg[0];
  assign segment1 = seg[1];
  assign segment2 = seg[2];
  assign segment3 = seg[3];
endmodule

// File: tb/tb_display_regs.sv
// Bench for display_regs: directed vector table, blink sequence, then randomized traffic vs a reference model.
module tb_display_regs;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] segment0, segment1, segment2, segment3;
  int         nchk = 0;
  int         nerr = 0;

  display_regs_if bus ();

  display_regs #(.BASE_ADDR(8'h10), .BLINK_DIV(24'(DIV))) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .segment0 (segment0),
    .segment1 (segment1),
    .segment2 (segment2),
    .segment3 (segment3)
  );

  always #5 clk = ~clk;

  // Reference model: register array plus the expected output bytes.
  logic [7:0] mregs [8];
  logic [7:0] mseg  [4];
  logic [7:0] min;
  bit         mphase;
  int         mcnt;
  logic [7:0] hex_t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
`ifdef DISPLAY_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  function automatic logic [7:0] seg_of(int g);
    logic [7:0] ctrl, dp;
    logic [15:0] dg;
    logic [3:0] nib;
    ctrl = mregs[3];
    dp   = mregs[2];
    dg   = {mregs[1], mregs[0]};
    nib  = dg[4*g +: 4];
    if (!ctrl[g])                 return 8'hFF;
    if (mphase && dp[4+g])        return 8'hFF;
    if (ctrl[4+g])                return mregs[4+g];
    if (dp[g])                    return hex_t[nib] & 8'h7F;
    return hex_t[nib];
  endfunction

  task automatic model_edge();
    logic [7:0] pid;
    pid = bus.port_id;
    if (reset) begin
      mregs = '{8'h00, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      for (int g = 0; g < 4; g++) mseg[g] = 8'hFF;
      min = 8'h00; mcnt = 0; mphase = 1'b0;
    end else begin
      for (int g = 0; g < 4; g++) mseg[g] = seg_of(g);
      min = (pid[7:3] == 5'b00010) ? mregs[pid[2:0]] : 8'h00;
      if (BLINK) begin
        if (mcnt == DIV - 1) begin mcnt = 0; mphase = ~mphase; end
        else mcnt++;
      end
      if (bus.write_strobe && pid[7:3] == 5'b00010)
        mregs[pid[2:0]] = (pid[2:0] == 3'd2 && !BLINK) ? (bus.out_port & 8'h0F) : bus.out_port;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %02h want %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input logic [7:0] pid, input bit ws, input logic [7:0] d);
    reset = r; bus.port_id = pid; bus.write_strobe = ws; bus.out_port = d;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_seg0"}, segment0, mseg[0]);
    chk({tag, "_seg1"}, segment1, mseg[1]);
    chk({tag, "_seg2"}, segment2, mseg[2]);
    chk({tag, "_seg3"}, segment3, mseg[3]);
    chk({tag, "_in"},   bus.in_port, min);
  endtask

  typedef struct {
    bit r; logic [7:0] pid; bit ws; logic [7:0] d;
    bit cs; logic [7:0] s0, s1, s2, s3, ip;
  } vec_t;

  vec_t tv [23];

  initial begin
    int seen_c0, seen_ff;
    tv[0]  = '{1, 8'h00, 0, 8'h00, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    tv[1]  = '{1, 8'h00, 0, 8'h00, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    tv[2]  = '{1, 8'h00, 0, 8'h00, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    tv[3]  = '{0, 8'h00, 0, 8'h00, 1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h00};
    tv[4]  = '{0, 8'h10, 1, 8'hA5, 1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h00};
    tv[5]  = '{0, 8'h11, 1, 8'h3F, 1, 8'h92, 8'h88, 8'hC0, 8'hC0, 8'h00};
    tv[6]  = '{0, 8'h12, 1, 8'h01, 1, 8'h92, 8'h88, 8'h8E, 8'hB0, 8'h00};
    tv[7]  = '{0, 8'h00, 0, 8'h00, 1, 8'h12, 8'h88, 8'h8E, 8'hB0, 8'h00};
    tv[8]  = '{0, 8'h13, 1, 8'h2B, 1, 8'h12, 8'h88, 8'h8E, 8'hB0, 8'h0F};
    tv[9]  = '{0, 8'h15, 1, 8'h7F, 1, 8'h12, 8'hFF, 8'hFF, 8'hB0, 8'hFF};
    tv[10] = '{0, 8'h13, 0, 8'h00, 1, 8'h12, 8'h7F, 8'hFF, 8'hB0, 8'h2B};
    tv[11] = '{0, 8'h18, 0, 8'h00, 1, 8'h12, 8'h7F, 8'hFF, 8'hB0, 8'h00};
    tv[12] = '{0, 8'h18, 1, 8'h55, 1, 8'h12, 8'h7F, 8'hFF, 8'hB0, 8'h00};
    tv[13] = '{0, 8'h10, 0, 8'h00, 1, 8'h12, 8'h7F, 8'hFF, 8'hB0, 8'hA5};
    tv[14] = '{0, 8'h15, 0, 8'h00, 1, 8'h12, 8'h7F, 8'hFF, 8'hB0, 8'h7F};
    tv[15] = '{0, 8'h11, 1, 8'h5A, 1, 8'h12, 8'h7F, 8'hFF, 8'hB0, 8'h3F};
    tv[16] = '{0, 8'h11, 0, 8'h00, 1, 8'h12, 8'h7F, 8'hFF, 8'h92, 8'h5A};
    tv[17] = '{0, 8'h10, 1, 8'h99, 1, 8'h12, 8'h7F, 8'hFF, 8'h92, 8'hA5};
    tv[18] = '{1, 8'h11, 1, 8'h77, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    tv[19] = '{0, 8'h11, 0, 8'h00, 1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h00};
    tv[20] = '{0, 8'h13, 0, 8'h00, 1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h0F};
    tv[21] = '{0, 8'h12, 1, 8'h10, 1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h00};
    tv[22] = '{0, 8'h12, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, BLINK ? 8'h10 : 8'h00};

    drive(1, 8'h00, 0, 8'h00);
    @(negedge clk);

    for (int i = 0; i < 23; i++) begin
      drive(tv[i].r, tv[i].pid, tv[i].ws, tv[i].d);
      tick();
      if (tv[i].cs) begin
        chk($sformatf("vec%0d_seg0", i), segment0, tv[i].s0);
        chk($sformatf("vec%0d_seg1", i), segment1, tv[i].s1);
        chk($sformatf("vec%0d_seg2", i), segment2, tv[i].s2);
        chk($sformatf("vec%0d_seg3", i), segment3, tv[i].s3);
      end
      chk($sformatf("vec%0d_in", i), bus.in_port, tv[i].ip);
    end

    // Blink mask on digit 0 is now set; digit 0 blanks only when the feature is built.
    seen_c0 = 0; seen_ff = 0;
    drive(0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 24; i++) begin
      tick();
      chk("blink_seg0", segment0, mseg[0]);
      chk("blink_seg1", segment1, 8'hC0);
      if (segment0 == 8'hC0) seen_c0++;
      if (segment0 == 8'hFF) seen_ff++;
    end
    chk("blink_seen_c0", 8'(seen_c0 != 0), 8'h01);
    chk("blink_seen_ff", 8'(seen_ff != 0), BLINK ? 8'h01 : 8'h00);

    // Randomized traffic, mostly inside the window, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] pid;
      pid = ($urandom_range(0, 3) != 0) ? {5'b00010, 3'($urandom_range(0, 7))} : 8'($urandom);
      drive(($urandom_range(0, 49) == 0), pid, 1'($urandom), 8'($urandom));
      tick();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
